// File: rtl/vending_simulation.sv
// Mini vending-machine controller: item/quantity select, coin totalling, change, 7-seg display.
// Latency: a button press or coin release is acted on 2 core clocks after the input edge.
// Backpressure: none; one event per press, coins past the display ceiling are rejected.
module vending_simulation #(
  parameter int PRICE0    = 75,
  parameter int PRICE1    = 100,
  parameter int PRICE2    = 110,
  parameter int PRICE3    = 120,
  parameter int PRICE4    = 150,
  parameter int MAX_CENTS = 999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cancel,
  input  logic        continue_,
  input  logic [4:0]  item_sel,
  input  logic [2:0]  amt_sel,
  input  logic        DIME,
  input  logic        QUATER,
  input  logic        DOLLAR,
  output logic [31:0] collected,
  output logic [31:0] change,
  output logic [7:0]  col_seven_1,
  output logic [7:0]  col_seven_2,
  output logic [7:0]  col_seven_3,
  output logic [7:0]  ch_seven_1,
  output logic [7:0]  ch_seven_2,
  output logic [7:0]  ch_seven_3,
  output logic [4:0]  item_LED,
  output logic [2:0]  amt_LED,
  output logic [2:0]  state,
  output logic [2:0]  next_state
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SELECT   = 3'd1,
    COLLECT  = 3'd2,
    DISPENSE = 3'd3,
    REFUND   = 3'd4
  } state_t;

  state_t     cur_q, nxt;
  logic [4:0] item_q, item_d;
  logic [2:0] amt_q, amt_d;
  logic [9:0] coll_q, coll_d;
  logic [9:0] chg_q, chg_d;

  // Input samples and their previous values (coins idle high)
  logic       cancel_r, cancel_p, cont_r, cont_p;
  logic       dime_r, dime_p, quat_r, quat_p, dol_r, dol_p;
  logic [4:0] item_r, item_p;
  logic [2:0] amt_r, amt_p;

  // Register the pushbuttons once and keep the prior sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cancel_r <= 1'b0;  cancel_p <= 1'b0;
      cont_r   <= 1'b0;  cont_p   <= 1'b0;
      item_r   <= '0;    item_p   <= '0;
      amt_r    <= '0;    amt_p    <= '0;
      dime_r   <= 1'b1;  dime_p   <= 1'b1;
      quat_r   <= 1'b1;  quat_p   <= 1'b1;
      dol_r    <= 1'b1;  dol_p    <= 1'b1;
    end else begin
      cancel_r <= cancel;    cancel_p <= cancel_r;
      cont_r   <= continue_; cont_p   <= cont_r;
      item_r   <= item_sel;  item_p   <= item_r;
      amt_r    <= amt_sel;   amt_p    <= amt_r;
      dime_r   <= DIME;      dime_p   <= dime_r;
      quat_r   <= QUATER;    quat_p   <= quat_r;
      dol_r    <= DOLLAR;    dol_p    <= dol_r;
    end
  end

  // Buttons fire on press, coins on release; multi-hot selections are discarded
  logic cancel_ev, cont_ev, item_ok, amt_ok, dime_ev, quat_ev, dol_ev, coin_ev;
  assign cancel_ev = cancel_r & ~cancel_p;
  assign cont_ev   = cont_r & ~cont_p;
  assign item_ok   = (item_p == 5'd0) && (item_r != 5'd0) && $onehot(item_r);
  assign amt_ok    = (amt_p == 3'd0) && (amt_r != 3'd0) && $onehot(amt_r);
  assign dime_ev   = dime_r & ~dime_p;
  assign quat_ev   = quat_r & ~quat_p;
  assign dol_ev    = dol_r & ~dol_p;
  assign coin_ev   = dime_ev | quat_ev | dol_ev;

  logic [9:0]  coin_val;
  logic [10:0] coll_sum;
  logic        coin_fits;

  // Only the most valuable coin of a simultaneous group is counted
  always_comb begin
    coin_val = 10'd0;
    if (dol_ev)       coin_val = 10'd100;
    else if (quat_ev) coin_val = 10'd25;
    else if (dime_ev) coin_val = 10'd10;
  end

  assign coll_sum  = {1'b0, coll_q} + {1'b0, coin_val};
  assign coin_fits = coin_ev && (coll_sum <= 11'(MAX_CENTS));

  logic [9:0]  unit_price;
  logic [1:0]  qty;
  logic [11:0] total;
  logic        funds_ok;

  // Price of the latched item and the quantity it is multiplied by
  always_comb begin
    unit_price = 10'd0;
    case (item_q)
      5'b00001: unit_price = 10'(PRICE0);
      5'b00010: unit_price = 10'(PRICE1);
      5'b00100: unit_price = 10'(PRICE2);
      5'b01000: unit_price = 10'(PRICE3);
      5'b10000: unit_price = 10'(PRICE4);
      default:  unit_price = 10'd0;
    endcase
    qty = 2'd0;
    case (amt_q)
      3'b001:  qty = 2'd1;
      3'b010:  qty = 2'd2;
      3'b100:  qty = 2'd3;
      default: qty = 2'd0;
    endcase
  end

  assign total    = 12'(unit_price) * 12'(qty);
  assign funds_ok = ({2'b00, coll_q} >= total);

  // Next state and next data; within a state the highest-priority relevant event wins
  always_comb begin
    nxt    = cur_q;
    item_d = item_q;
    amt_d  = amt_q;
    coll_d = coll_q;
    chg_d  = chg_q;
    case (cur_q)
      IDLE: begin
        if (item_ok) begin
          nxt = SELECT; item_d = item_r; amt_d = 3'b001; coll_d = '0; chg_d = '0;
        end
      end
      SELECT: begin
        if (cancel_ev) begin
          nxt = REFUND; chg_d = coll_q;
        end else if (item_ok) begin
          item_d = item_r;
        end else if (amt_ok) begin
          amt_d = amt_r;
        end else if (coin_fits) begin
          nxt = COLLECT; coll_d = coll_sum[9:0];
        end
      end
      COLLECT: begin
        if (cancel_ev) begin
          nxt = REFUND; chg_d = coll_q;
        end else if (cont_ev) begin
          if (funds_ok) begin
            nxt = DISPENSE; chg_d = 10'({2'b00, coll_q} - total);
          end
        end else if (amt_ok) begin
          amt_d = amt_r;
        end else if (coin_fits) begin
          coll_d = coll_sum[9:0];
        end
      end
      DISPENSE, REFUND: begin
        if (cont_ev) begin
          nxt = IDLE; item_d = '0; amt_d = '0; coll_d = '0; chg_d = '0;
        end else if (item_ok) begin
          nxt = SELECT; item_d = item_r; amt_d = 3'b001; coll_d = '0; chg_d = '0;
        end
      end
      default: begin
        nxt = IDLE; item_d = '0; amt_d = '0; coll_d = '0; chg_d = '0;
      end
    endcase
  end

  // Commit state and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= IDLE;
      item_q <= '0;
      amt_q  <= '0;
      coll_q <= '0;
      chg_q  <= '0;
    end else begin
      cur_q  <= nxt;
      item_q <= item_d;
      amt_q  <= amt_d;
      coll_q <= coll_d;
      chg_q  <= chg_d;
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  // Three digits (hundreds, tens, units), clamped to the displayable range
  function automatic logic [23:0] segs3(input logic [9:0] x);
    logic [9:0] v;
    v = (x > 10'd999) ? 10'd999 : x;
    segs3 = {seg7(4'(v / 10'd100)), seg7(4'((v / 10'd10) % 10'd10)), seg7(4'(v % 10'd10))};
  endfunction

  assign {col_seven_1, col_seven_2, col_seven_3} = segs3(coll_q);
  assign {ch_seven_1, ch_seven_2, ch_seven_3}    = segs3(chg_q);

  assign collected  = {22'd0, coll_q};
  assign change     = {22'd0, chg_q};
  assign item_LED   = item_q;
  assign amt_LED    = amt_q;
  assign state      = cur_q;
  assign next_state = nxt;

endmodule

// File: tb/tb_vending_simulation.sv
module tb_vending_simulation;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cancel = 1'b0, continue_ = 1'b0;
  logic [4:0]  item_sel = 5'd0;
  logic [2:0]  amt_sel = 3'd0;
  logic        DIME = 1'b1, QUATER = 1'b1, DOLLAR = 1'b1;
  logic [31:0] collected, change;
  logic [7:0]  col_seven_1, col_seven_2, col_seven_3;
  logic [7:0]  ch_seven_1, ch_seven_2, ch_seven_3;
  logic [4:0]  item_LED;
  logic [2:0]  amt_LED;
  logic [2:0]  state, next_state;

  vending_simulation dut (
    .clk(clk), .rst_n(rst_n), .cancel(cancel), .continue_(continue_),
    .item_sel(item_sel), .amt_sel(amt_sel),
    .DIME(DIME), .QUATER(QUATER), .DOLLAR(DOLLAR),
    .collected(collected), .change(change),
    .col_seven_1(col_seven_1), .col_seven_2(col_seven_2), .col_seven_3(col_seven_3),
    .ch_seven_1(ch_seven_1), .ch_seven_2(ch_seven_2), .ch_seven_3(ch_seven_3),
    .item_LED(item_LED), .amt_LED(amt_LED),
    .state(state), .next_state(next_state)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: mode numbers 0 idle, 1 select, 2 collect, 3 dispense, 4 refund
  int m_mode, m_item, m_qty, m_coll, m_chg;
  int prices [5] = '{75, 100, 110, 120, 150};
  logic [7:0] seg_tab [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [4:0] v);
    for (int i = 0; i < 5; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [23:0] exp_segs(input int x);
    int v;
    v = (x > 999) ? 999 : x;
    return {seg_tab[v / 100], seg_tab[(v / 10) % 10], seg_tab[v % 10]};
  endfunction

  task automatic m_reset();
    m_mode = 0; m_item = -1; m_qty = 0; m_coll = 0; m_chg = 0;
  endtask

  task automatic m_new_item(input logic [4:0] v);
    m_mode = 1; m_item = idx_of(v); m_qty = 1; m_coll = 0; m_chg = 0;
  endtask

  task automatic m_item_ev(input logic [4:0] v);
    if ($countones(v) != 1) return;
    if (m_mode == 1) m_item = idx_of(v);
    else if (m_mode != 2) m_new_item(v);
  endtask

  task automatic m_amt_ev(input logic [2:0] v);
    if ($countones(v) != 1) return;
    if (m_mode == 1 || m_mode == 2) m_qty = (v == 3'b001) ? 1 : (v == 3'b010) ? 2 : 3;
  endtask

  task automatic m_coin_ev(input int cents);
    if ((m_mode == 1 || m_mode == 2) && m_coll + cents <= 999) begin
      m_coll += cents;
      m_mode = 2;
    end
  endtask

  task automatic m_ctl_ev(input bit c, input bit k);
    if (c && (m_mode == 1 || m_mode == 2)) begin
      m_chg = m_coll; m_mode = 4;
    end else if (k && m_mode == 2) begin
      if (m_coll >= prices[m_item] * m_qty) begin
        m_chg = m_coll - prices[m_item] * m_qty; m_mode = 3;
      end
    end else if (k && (m_mode == 3 || m_mode == 4)) begin
      m_reset();
    end
  endtask

  task automatic check_all(input string w);
    chk({w, "/state"}, 32'(state), 32'(m_mode));
    chk({w, "/next_state"}, 32'(next_state), 32'(m_mode));
    chk({w, "/collected"}, collected, 32'(m_coll));
    chk({w, "/change"}, change, 32'(m_chg));
    chk({w, "/item_LED"}, 32'(item_LED), (m_item < 0) ? 32'd0 : (32'd1 << m_item));
    chk({w, "/amt_LED"}, 32'(amt_LED), (m_qty == 0) ? 32'd0 : (32'd1 << (m_qty - 1)));
    chk({w, "/col_seg"}, 32'({col_seven_1, col_seven_2, col_seven_3}), 32'(exp_segs(m_coll)));
    chk({w, "/ch_seg"}, 32'({ch_seven_1, ch_seven_2, ch_seven_3}), 32'(exp_segs(m_chg)));
  endtask

  // Button stimulus, called at a negedge; returns at a negedge after the event has settled
  task automatic press(input bit c, input bit k, input logic [4:0] it, input logic [2:0] am);
    cancel = c; continue_ = k; item_sel = it; amt_sel = am;
    repeat (2) @(negedge clk);
    cancel = 1'b0; continue_ = 1'b0; item_sel = 5'd0; amt_sel = 3'd0;
    repeat (3) @(negedge clk);
    if (c || k) m_ctl_ev(c, k);
    else if (it != 5'd0) m_item_ev(it);
    else m_amt_ev(am);
    check_all(c ? (k ? "cancel_cont" : "cancel") : k ? "cont" : (it != 5'd0) ? "item" : "amt");
  endtask

  task automatic coin(input int cents);
    DIME = (cents != 10); QUATER = (cents != 25); DOLLAR = (cents != 100);
    repeat (2) @(negedge clk);
    DIME = 1'b1; QUATER = 1'b1; DOLLAR = 1'b1;
    repeat (3) @(negedge clk);
    m_coin_ev(cents);
    check_all("coin");
  endtask

  int coin_vals [3] = '{10, 25, 100};

  initial begin
    m_reset();
    repeat (3) @(negedge clk);
    check_all("reset_held");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset_colseg", 32'({col_seven_1, col_seven_2, col_seven_3}), 32'h3F3F3F);

    // Event latency: nothing after the first edge, state moves on the second
    item_sel = 5'b00001;
    @(posedge clk); #1;
    chk("lat_edge1_state", 32'(state), 32'd0);
    chk("lat_edge1_next", 32'(next_state), 32'd1);
    @(posedge clk); #1;
    chk("lat_edge2_state", 32'(state), 32'd1);
    @(negedge clk);
    item_sel = 5'd0;
    repeat (3) @(negedge clk);
    m_item_ev(5'b00001);
    check_all("lat_item");

    coin(10); coin(100);
    press(0, 1, 0, 0);
    chk("s1_collected", collected, 32'd110);
    chk("s1_change", change, 32'd35);
    chk("s1_state", 32'(state), 32'd3);
    chk("s1_chseg", 32'({ch_seven_1, ch_seven_2, ch_seven_3}), 32'h3F4F6D);

    press(0, 0, 5'b00010, 0);
    coin(10);
    press(1, 0, 0, 0);
    chk("s2_change", change, 32'd10);
    chk("s2_state", 32'(state), 32'd4);
    press(0, 1, 0, 0);
    chk("s2_idle", 32'(state), 32'd0);

    press(0, 0, 5'b01000, 0);
    press(0, 0, 0, 3'b100);
    coin(100); coin(100); coin(100); coin(25); coin(25); coin(10);
    press(0, 1, 0, 0);
    chk("s3_collected", collected, 32'd360);
    chk("s3_change", change, 32'd0);
    chk("s3_state", 32'(state), 32'd3);
    press(0, 1, 0, 0);

    press(0, 0, 5'b10000, 0);
    coin(100);
    press(0, 1, 0, 0);
    chk("s4_short", 32'(state), 32'd2);
    coin(25); coin(25);
    press(0, 1, 0, 0);
    chk("s4_change", change, 32'd0);
    chk("s4_state", 32'(state), 32'd3);

    press(0, 0, 5'b00100, 0);
    press(0, 0, 5'b00011, 0);
    press(0, 0, 0, 3'b011);
    coin(10);
    press(1, 1, 0, 0);
    chk("s5_refund", 32'(state), 32'd4);
    press(0, 0, 5'b00001, 0);
    for (int i = 0; i < 10; i++) coin(100);
    chk("s5_cap", collected, 32'd900);

    // Asynchronous reset in the middle of a transaction
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_collected", collected, 32'd0);
    chk("arst_item", 32'(item_LED), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_all("after_arst");

    // Randomized operation sequence against the model
    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 11))
        0, 1:    press(0, 0, 5'd1 << $urandom_range(0, 4), 0);
        2:       press(0, 0, 5'($urandom), 0);
        3:       press(0, 0, 0, 3'd1 << $urandom_range(0, 2));
        4:       press(0, 0, 0, 3'($urandom));
        5, 6, 7: coin(coin_vals[$urandom_range(0, 2)]);
        8, 9:    press(0, 1, 0, 0);
        10:      press(1, 0, 0, 0);
        default: press(1, 1, 0, 0);
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
